// File: rtl/bcd_tick_counter.sv
// Four-digit BCD event counter driven by edges of a slow tick on the system clock.
// Optional HOLD_AT_MAX_EN: saturate at 9999 and pause instead of wrapping.
module bcd_tick_counter #(
  parameter int unsigned TICK_BOTH_EDGES = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_in,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic       running,
  output logic       wrap
);

  typedef enum logic [1:0] {StIdle, StRun, StPause} state_e;

  state_e     state_q, state_d;
  logic       tick_q;
  logic [3:0] digit_q [4];
  logic [3:0] digit_d [4];
  logic [3:0] digit_inc [4];
  logic [3:0] carry;
  logic       running_q, running_d;
  logic       wrap_q, wrap_d;
  logic       rise, fall, tick_ev, at_max, count_en;

  always_comb begin
    rise    = tick_in & ~tick_q;
    fall    = ~tick_in & tick_q;
    tick_ev = (TICK_BOTH_EDGES != 0) ? (rise | fall) : rise;
  end

  // Ripple-carry BCD increment of the whole count.
  always_comb begin
    carry[0] = 1'b1;
    for (int i = 1; i < 4; i++) begin
      carry[i] = carry[i-1] && (digit_q[i-1] == 4'd9);
    end
    for (int i = 0; i < 4; i++) begin
      if (!carry[i]) begin
        digit_inc[i] = digit_q[i];
      end else if (digit_q[i] == 4'd9) begin
        digit_inc[i] = 4'd0;
      end else begin
        digit_inc[i] = digit_q[i] + 4'd1;
      end
    end
    at_max = carry[3] && (digit_q[3] == 4'd9);
  end

  always_comb begin
    state_d  = state_q;
    digit_d  = digit_q;
    wrap_d   = 1'b0;
    count_en = (state_q == StRun) && tick_ev;
    if (clear) begin
      state_d = StIdle;
      digit_d = '{default: 4'd0};
    end else begin
      if (stop) begin
        if (state_q == StRun) begin
          state_d = StPause;
        end
      end else if (start) begin
        state_d = StRun;
      end
      // Counting keys off the registered state, so stop+tick still counts.
      if (count_en) begin
        wrap_d = at_max;
`ifdef HOLD_AT_MAX_EN
        if (at_max) begin
          state_d = StPause;
        end else begin
          digit_d = digit_inc;
        end
`else
        digit_d = digit_inc;
`endif
      end
    end
    running_d = (state_d == StRun);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      tick_q    <= 1'b0;
      digit_q   <= '{default: 4'd0};
      running_q <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_in;
      digit_q   <= digit_d;
      running_q <= running_d;
      wrap_q    <= wrap_d;
    end
  end

  assign digit0  = digit_q[0];
  assign digit1  = digit_q[1];
  assign digit2  = digit_q[2];
  assign digit3  = digit_q[3];
  assign running = running_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Bench for bcd_tick_counter: rising-edge and both-edge instances share stimulus;
// a decimal reference model feeds per-instance scoreboards, plus a vector table.
module tb_bcd_tick_counter;

  logic clk = 1'b0;
  logic rst_n, tick_in, start, stop, clear;
  logic [3:0] a_d0, a_d1, a_d2, a_d3, b_d0, b_d1, b_d2, b_d3;
  logic a_run, a_wrap, b_run, b_wrap;

  always #5 clk = ~clk;

  bcd_tick_counter #(.TICK_BOTH_EDGES(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .tick_in(tick_in), .start(start), .stop(stop), .clear(clear),
    .digit0(a_d0), .digit1(a_d1), .digit2(a_d2), .digit3(a_d3),
    .running(a_run), .wrap(a_wrap)
  );

  bcd_tick_counter #(.TICK_BOTH_EDGES(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .tick_in(tick_in), .start(start), .stop(stop), .clear(clear),
    .digit0(b_d0), .digit1(b_d1), .digit2(b_d2), .digit3(b_d3),
    .running(b_run), .wrap(b_wrap)
  );

  wire [17:0] obs_a = {a_d3, a_d2, a_d1, a_d0, a_run, a_wrap};
  wire [17:0] obs_b = {b_d3, b_d2, b_d1, b_d0, b_run, b_wrap};

  typedef struct {
    logic [15:0] cnt;
    logic        run;
    logic        wrap;
  } exp_t;

  typedef struct {
    bit          rn, tk, sa, so, cl;
    logic [15:0] cnt;
    bit          run, wrap;
  } vec_t;

  exp_t sb_a[$];
  exp_t sb_b[$];
  vec_t vt[$];

  int total = 0;
  int bad   = 0;

  // Reference model state per instance: 0 idle, 1 run, 2 pause.
  int m_cnt[2];
  int m_st[2];
  bit m_prev[2];
  bit m_wrap[2];

  function automatic logic [15:0] to_bcd(input int n);
    return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
  endfunction

  task automatic chk(input string name, input logic [17:0] act, input logic [17:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  task automatic model(input int k, input bit both, input bit rn, input bit tk, input bit sa,
                       input bit so, input bit cl);
    bit ev;
    int old;
    if (!rn) begin
      m_cnt[k] = 0; m_st[k] = 0; m_prev[k] = 0; m_wrap[k] = 0;
      return;
    end
    ev  = both ? (tk != m_prev[k]) : (tk && !m_prev[k]);
    old = m_st[k];
    m_wrap[k] = 0;
    if (cl) begin
      m_cnt[k] = 0;
      m_st[k]  = 0;
    end else begin
      if (so) begin
        if (old == 1) m_st[k] = 2;
      end else if (sa) begin
        m_st[k] = 1;
      end
      if (old == 1 && ev) begin
        if (m_cnt[k] == 9999) begin
          m_wrap[k] = 1;
`ifdef HOLD_AT_MAX_EN
          m_st[k] = 2;
`else
          m_cnt[k] = 0;
`endif
        end else begin
          m_cnt[k] = m_cnt[k] + 1;
        end
      end
    end
    m_prev[k] = tk;
  endtask

  task automatic cyc(input bit rn, input bit tk, input bit sa, input bit so, input bit cl);
    exp_t e;
    rst_n = rn; tick_in = tk; start = sa; stop = so; clear = cl;
    model(0, 1'b0, rn, tk, sa, so, cl);
    model(1, 1'b1, rn, tk, sa, so, cl);
    e.cnt = to_bcd(m_cnt[0]); e.run = (m_st[0] == 1); e.wrap = m_wrap[0];
    sb_a.push_back(e);
    e.cnt = to_bcd(m_cnt[1]); e.run = (m_st[1] == 1); e.wrap = m_wrap[1];
    sb_b.push_back(e);
    @(posedge clk);
    #1;
    e = sb_a.pop_front();
    chk("model_rise", obs_a, {e.cnt, e.run, e.wrap});
    e = sb_b.pop_front();
    chk("model_both", obs_b, {e.cnt, e.run, e.wrap});
  endtask

  task automatic add(input bit rn, input bit tk, input bit sa, input bit so, input bit cl,
                     input int n, input bit run, input bit wr);
    vec_t v;
    v.rn = rn; v.tk = tk; v.sa = sa; v.so = so; v.cl = cl;
    v.cnt = to_bcd(n); v.run = run; v.wrap = wr;
    vt.push_back(v);
  endtask

  initial begin
    // Vector table: reset, start, count to 5, stop+tick, pause, resume, count to 42, clear+tick.
    add(0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 1, 0, 0, 0, 1, 0);
    for (int k = 1; k <= 5; k++) begin
      add(1, 1, 0, 0, 0, k, 1, 0);
      add(1, 0, 0, 0, 0, k, 1, 0);
    end
    add(1, 1, 0, 1, 0, 6, 0, 0);
    add(1, 0, 0, 0, 0, 6, 0, 0);
    add(1, 1, 0, 0, 0, 6, 0, 0);
    add(1, 0, 0, 0, 0, 6, 0, 0);
    add(1, 1, 1, 0, 0, 6, 1, 0);
    add(1, 0, 0, 0, 0, 6, 1, 0);
    for (int k = 7; k <= 42; k++) begin
      add(1, 1, 0, 0, 0, k, 1, 0);
      add(1, 0, 0, 0, 0, k, 1, 0);
    end
    add(1, 1, 0, 0, 1, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 0, 0, 0, 0);
    add(1, 1, 1, 0, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0, 1, 0);

    foreach (vt[i]) begin
      cyc(vt[i].rn, vt[i].tk, vt[i].sa, vt[i].so, vt[i].cl);
      chk($sformatf("vec%0d", i), obs_a, {vt[i].cnt, vt[i].run, vt[i].wrap});
    end

    // Carry 0099 -> 0100.
    for (int n = 1; n <= 99; n++) begin
      cyc(1, 1, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
    end
    chk("at_0099", obs_a, {16'h0099, 1'b1, 1'b0});
    cyc(1, 1, 0, 0, 0);
    chk("carry_0100", obs_a, {16'h0100, 1'b1, 1'b0});
    cyc(1, 0, 0, 0, 0);

    // Run up to 9999, then one more edge.
    for (int n = 101; n <= 9999; n++) begin
      cyc(1, 1, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
    end
    chk("at_9999", obs_a, {16'h9999, 1'b1, 1'b0});
    cyc(1, 1, 0, 0, 0);
`ifdef HOLD_AT_MAX_EN
    chk("hold_max", obs_a, {16'h9999, 1'b0, 1'b1});
`else
    chk("wrap_0000", obs_a, {16'h0000, 1'b1, 1'b1});
`endif
    cyc(1, 0, 0, 0, 0);
`ifdef HOLD_AT_MAX_EN
    chk("hold_after", obs_a, {16'h9999, 1'b0, 1'b0});
`else
    chk("wrap_after", obs_a, {16'h0000, 1'b1, 1'b0});
`endif

    // Both-edge counting from a clean reset, then reset mid-stream.
    cyc(0, 0, 0, 0, 0);
    chk("reset_a", obs_a, 18'h0);
    chk("reset_b", obs_b, 18'h0);
    cyc(1, 0, 1, 0, 0);
    chk("start_b", obs_b, {16'h0000, 1'b1, 1'b0});
    for (int p = 0; p < 5; p++) begin
      cyc(1, 1, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
    end
    chk("both_0010", obs_b, {16'h0010, 1'b1, 1'b0});
    chk("rise_0005", obs_a, {16'h0005, 1'b1, 1'b0});
    cyc(1, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("midreset_a", obs_a, 18'h0);
    chk("midreset_b", obs_b, 18'h0);
    cyc(1, 1, 0, 0, 0);
    chk("idle_after_b", obs_b, 18'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_tick_counter.md
# bcd_tick_counter

Four-digit BCD event counter that consumes the slow toggling output of the clock divider as a data input on the system clock. It detects tick edges and, under start/stop/clear control, counts 0000–9999 for the seven-segment display path. All logic runs on the single system clock; the divided signal is never used as a clock.

## Interface

Parameters:
- TICK_BOTH_EDGES, 0, when 0 count rising edges of tick_in only; when 1 count rising and falling edges.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- tick_in  input  1  divided toggle signal, already registered on clk.
- start  input  1  single-cycle pulse; begin or resume counting.
- stop  input  1  single-cycle pulse; pause counting.
- clear  input  1  single-cycle pulse; zero count, go idle.
- digit0  output  4  BCD units.
- digit1  output  4  BCD tens.
- digit2  output  4  BCD hundreds.
- digit3  output  4  BCD thousands.
- running  output  1  high while in RUN.
- wrap  output  1  one-cycle pulse when the count passes 9999.

## Operation

- Edge detect: tick_d register holds the previous tick_in.
  - rise = tick_in & ~tick_d.
  - fall = ~tick_in & tick_d.
  - tick_ev = rise, or rise|fall when TICK_BOTH_EDGES=1.
- FSM states: IDLE, RUN, PAUSE.
  - IDLE → RUN on start.
  - RUN → PAUSE on stop.
  - PAUSE → RUN on start.
  - Any state → IDLE on clear.
  - start in RUN is ignored; stop in IDLE or PAUSE is ignored.
- Control priority in one cycle: clear > stop > start.
- Counting happens only when the state register is already RUN and tick_ev=1 in the same cycle. There are no other count sources.
- BCD increment:
  - digit0 increments; at 9 it goes to 0 and carries into digit1.
  - The carry ripples the same way through digit3. Each digit stays within 0–9.
- Wrap: 9999 + tick_ev gives 0000, wrap=1 for that one cycle, and the FSM stays in RUN.
- clear forces all digits to 0 and the state to IDLE, regardless of tick_ev.
- Simultaneous events:
  - clear with tick_ev: result is 0000 and IDLE; no wrap pulse.
  - stop with tick_ev in RUN: the tick is counted. The state sampled was RUN; the count updates and the state goes to PAUSE on the same edge.
  - start with tick_ev in IDLE or PAUSE: the tick is not counted.
- Reset mid-count: the next clk edge with rst_n=0 returns everything to reset values. The count is lost.

## Timing

- Reset values:
  - digit0–digit3 = 0.
  - running = 0.
  - wrap = 0.
  - tick_d = 0.
  - state = IDLE.
- tick_ev is combinational from tick_in and tick_d. The digits update on the clk edge that samples the edge, so they change 1 clk after tick_in changes.
- running is registered and asserts 1 clk after the start pulse.
- wrap is registered and coincident with the digits becoming 0000.
- Minimum tick_in period: 2 clk for either TICK_BOTH_EDGES setting. The divider guarantees far more.

## Configuration

- HOLD_AT_MAX_EN:
  - Defined: at 9999, tick_ev leaves the digits at 9999, pulses wrap once, and moves RUN → PAUSE. start from PAUSE at 9999 resumes RUN, and the next tick_ev repeats the hold-and-pause. Only clear or reset leaves 9999.
  - Undefined: 9999 wraps to 0000 and counting continues, as described under Operation.

## Test plan

- Reset, then start, then 12 rising edges on tick_in → digits 0012, running=1, wrap never asserted.
- Preload by counting to 0099, then one more tick → 0100. Check the digit1 and digit2 carry, with digit0=0 and digit1=0 on the same edge.
- Count to 9999, then one tick:
  - Without macro → 0000, wrap=1 for exactly 1 clk, running=1.
  - With HOLD_AT_MAX_EN → 9999, wrap pulse, running=0.
- In RUN at 0005:
  - stop and rising edge in the same cycle → 0006, then running=0.
  - Further edges → count stays 0006.
  - start → counting resumes at the next edge.
- At 0042, clear together with a rising edge → 0000, running=0, wrap=0.
- TICK_BOTH_EDGES=1, 5 full tick_in periods in RUN → 0010. Assert rst_n=0 for one clk mid-stream → all outputs 0, state IDLE.
